blake2s_msg_packer: RTL and testbench

//  Write side of the BLAKE2s message-block interface. Accepts a 32-bit word

---
 rtl/blake2s_msg_packer.sv | 96 +++++++++
 tb/tb_blake2s_msg_packer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/blake2s_msg_packer.sv
// BLAKE2s message-block write side: packs a 32-bit word stream into 512-bit
// blocks, tracks the byte counter t, and hands each block out with valid/ready.
module blake2s_msg_packer #(
  parameter int T_WIDTH = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_data,
  input  logic               in_last,
  input  logic [2:0]         in_nbytes,
  output logic               blk_valid,
  input  logic               blk_ready,
  output logic [511:0]       blk_m,
  output logic [T_WIDTH-1:0] blk_t,
  output logic               blk_final,
  output logic               state_dbg
);

  // Handshake: a transfer happens on a rising clk edge where valid && ready;
  // the producer holds its payload stable until that edge, and valid never
  // depends on ready.

  typedef enum logic {FILL = 1'b0, EMIT = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [3:0]         idx;
  logic [T_WIDTH-1:0] cnt;
  logic               accept;
  logic               blk_done;
  logic [31:0]        swapped;
  logic [31:0]        word_masked;
  logic [2:0]         nb_eff;

  assign state_dbg = state;
  assign blk_t     = cnt;
  assign blk_done  = in_last || (idx == 4'd15);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FILL;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    blk_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid && blk_done) state_nxt = EMIT;
      end
      EMIT: begin
        blk_valid = 1'b1;
        if (blk_ready) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  // Earliest byte lands in the most significant lane; bytes past the end of a
  // last word are zeroed so partial blocks come out padded.
  always_comb begin
    swapped     = {in_data[7:0], in_data[15:8], in_data[23:16], in_data[31:24]};
    nb_eff      = 3'd4;
    word_masked = 32'd0;
    if (in_last) nb_eff = (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < nb_eff) word_masked[31-8*i -: 8] = swapped[31-8*i -: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blk_m     <= '0;
      blk_final <= 1'b0;
      idx       <= 4'd0;
      cnt       <= '0;
    end else if (accept) begin
      blk_m[{~idx, 5'd0} +: 32] <= word_masked;
      cnt                       <= cnt + T_WIDTH'(nb_eff);
      blk_final                 <= in_last;
      if (!blk_done) idx <= idx + 4'd1;
    end else if (state == EMIT && blk_ready) begin
      blk_m     <= '0;
      idx       <= 4'd0;
      blk_final <= 1'b0;
      // The counter only restarts once the final block of a message has gone.
      if (blk_final) cnt <= '0;
    end
  end

endmodule

// File: tb/tb_blake2s_msg_packer.sv
// Directed bench for blake2s_msg_packer: single-word vector table plus
// hand-written sequences for full blocks, two-block messages, stalls and reset.
module tb_blake2s_msg_packer;

  localparam int T_WIDTH = 64;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        in_data;
  logic               in_last;
  logic [2:0]         in_nbytes;
  logic               blk_valid;
  logic               blk_ready;
  logic [511:0]       blk_m;
  logic [T_WIDTH-1:0] blk_t;
  logic               blk_final;
  logic               state_dbg;

  int checks = 0;
  int errors = 0;

  logic [576:0] exp_q[$];

  blake2s_msg_packer #(.T_WIDTH(T_WIDTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_nbytes(in_nbytes),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_m(blk_m),
    .blk_t(blk_t), .blk_final(blk_final), .state_dbg(state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]        data;
    logic [2:0]         nb;
    logic [31:0]        exp_word;
    logic [T_WIDTH-1:0] exp_t;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
    int n = 0;
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = d;
    in_last   = last;
    in_nbytes = nb;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      timeout("in_ready");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic expect_block(input logic [511:0] m, input logic [T_WIDTH-1:0] t, input logic f);
    exp_q.push_back({m, t, f});
  endtask

  task automatic get_block();
    int n = 0;
    logic [576:0] e;
    @(negedge clk);
    while (!blk_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!blk_valid) begin
      timeout("blk_valid");
      return;
    end
    if (exp_q.size() == 0) begin
      timeout("exp_q empty");
      return;
    end
    e = exp_q.pop_front();
    chk("blk_m", blk_m, e[576:65]);
    chk("blk_t", 512'(blk_t), 512'(e[64:1]));
    chk("blk_final", 512'(blk_final), 512'(e[0]));
    blk_ready = 1'b1;
    @(posedge clk);
    #1 blk_ready = 1'b0;
  endtask

  task automatic send_ramp(input int nwords, input logic last_on_end);
    for (int i = 0; i < nwords; i++)
      send_word({8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)},
                last_on_end && (i == nwords - 1), 3'd4);
  endtask

  initial begin
    logic [511:0] ramp;
    logic [511:0] bp_m;

    vecs[0] = '{32'h00636261, 3'd3, 32'h61626300, 64'd3};
    vecs[1] = '{32'h44332211, 3'd4, 32'h11223344, 64'd4};
    vecs[2] = '{32'h44332211, 3'd1, 32'h11000000, 64'd1};
    vecs[3] = '{32'h44332211, 3'd2, 32'h11220000, 64'd2};
    vecs[4] = '{32'h44332211, 3'd0, 32'h00000000, 64'd0};
    vecs[5] = '{32'h44332211, 3'd7, 32'h11223344, 64'd4};
    vecs[6] = '{32'hdeadbeef, 3'd5, 32'hefbeadde, 64'd4};
    vecs[7] = '{32'hcafe0102, 3'd3, 32'h0201fe00, 64'd3};

    for (int b = 0; b < 64; b++) ramp[511-8*b -: 8] = 8'(b);

    // reset
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    in_nbytes = '0; blk_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst in_ready", 512'(in_ready), 512'd1);
    chk("rst blk_valid", 512'(blk_valid), 512'd0);
    chk("rst blk_m", blk_m, 512'd0);
    chk("rst blk_t", 512'(blk_t), 512'd0);
    chk("rst blk_final", 512'(blk_final), 512'd0);
    reset = 1'b0;

    // one-word messages: masking, nbytes clamping, empty message
    for (int v = 0; v < 8; v++) begin
      expect_block({vecs[v].exp_word, 480'd0}, vecs[v].exp_t, 1'b1);
      send_word(vecs[v].data, 1'b1, vecs[v].nb);
      get_block();
    end

    // exactly 64 bytes: no extra block, input stalled until consumed
    send_ramp(16, 1'b1);
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      chk("full in_ready", 512'(in_ready), 512'd0);
      chk("full blk_valid", 512'(blk_valid), 512'd1);
      @(negedge clk);
    end
    expect_block(ramp, 64'd64, 1'b1);
    get_block();
    @(negedge clk);
    chk("full no extra blk", 512'(blk_valid), 512'd0);

    // 65 bytes: two blocks, counter continues across the first
    send_ramp(16, 1'b0);
    expect_block(ramp, 64'd64, 1'b0);
    get_block();
    send_word(32'h00000040, 1'b1, 3'd1);
    expect_block({8'h40, 504'd0}, 64'd65, 1'b1);
    get_block();

    // backpressure with an offered word that must be ignored
    bp_m = {32'h01020304, 480'd0};
    send_word(32'h04030201, 1'b1, 3'd4);
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'hffffffff; in_last = 1'b0; in_nbytes = 3'd4;
    for (int c = 0; c < 5; c++) begin
      chk("bp blk_valid", 512'(blk_valid), 512'd1);
      chk("bp in_ready", 512'(in_ready), 512'd0);
      chk("bp blk_m", blk_m, bp_m);
      chk("bp blk_t", 512'(blk_t), 512'd4);
      chk("bp blk_final", 512'(blk_final), 512'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    blk_ready = 1'b1;
    @(posedge clk);
    #1 blk_ready = 1'b0;
    @(negedge clk);
    chk("bp after blk_valid", 512'(blk_valid), 512'd0);
    chk("bp after in_ready", 512'(in_ready), 512'd1);
    chk("bp after blk_m", blk_m, 512'd0);
    expect_block({32'h61626300, 480'd0}, 64'd3, 1'b1);
    send_word(32'h00636261, 1'b1, 3'd3);
    get_block();

    // reset mid-fill aborts the message
    send_ramp(7, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst in_ready", 512'(in_ready), 512'd1);
    chk("midrst blk_valid", 512'(blk_valid), 512'd0);
    chk("midrst blk_m", blk_m, 512'd0);
    chk("midrst blk_t", 512'(blk_t), 512'd0);
    @(negedge clk);
    reset = 1'b0;
    expect_block({32'h61626300, 480'd0}, 64'd3, 1'b1);
    send_word(32'h00636261, 1'b1, 3'd3);
    get_block();

    chk("exp_q drained", 512'(exp_q.size()), 512'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
